// File: rtl/intr_pkg.sv
// Shared register map for the interrupt controller.
package intr_pkg;
    localparam logic [1:0] INTR_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] INTR_ADDR_PENDING = 2'd1;
    localparam logic [1:0] INTR_ADDR_MODE    = 2'd2;
    localparam logic [1:0] INTR_ADDR_SOFT    = 2'd3;
endpackage

// File: rtl/intr_priority_encoder.sv
// Fixed-priority encoder: reports the lowest-numbered active source.
module intr_priority_encoder #(
    parameter int N_SRC = 4,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] active,
    output logic             any,
    output logic [ID_W-1:0]  id
);
    always_comb begin
        any = |active;
        id  = '0;
        // Scan downwards so the lowest set index is the last one assigned.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                id = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller with per-source enable, edge/level mode,
// W1C/soft-set pending register, ack handshake and registered irq/id outputs.
module interrupt_controller
    import intr_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             write_signal,
    input  logic [1:0]       write_addr,
    input  logic [N_SRC-1:0] write_data,
    input  logic [1:0]       read_addr,
    output logic [N_SRC-1:0] read_data,
    input  logic             irq_ack,
    output logic             interrupt_signal,
    output logic [ID_W-1:0]  irq_id
);
    logic [N_SRC-1:0] enable_reg;
    logic [N_SRC-1:0] mode_reg;
    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] src_prev_reg;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] active;
    logic             any_active;
    logic [ID_W-1:0]  top_id;

    logic wr_enable, wr_pending, wr_mode, wr_soft, ack_valid;

    assign wr_enable  = write_signal && (write_addr == INTR_ADDR_ENABLE);
    assign wr_pending = write_signal && (write_addr == INTR_ADDR_PENDING);
    assign wr_mode    = write_signal && (write_addr == INTR_ADDR_MODE);
    assign wr_soft    = write_signal && (write_addr == INTR_ADDR_SOFT);
    assign ack_valid  = irq_ack && interrupt_signal;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            logic rise, set_bit, clr_bit;
            assign rise    = src_in[gi] & ~src_prev_reg[gi];
            assign set_bit = rise | (wr_soft & write_data[gi]);
            assign clr_bit = (wr_pending & write_data[gi]) |
                             (ack_valid & (irq_id == ID_W'(gi)));
            // Set beats clear so a new event arriving with a clear is never lost.
            assign pending_next[gi] = mode_reg[gi]
                                    ? (set_bit | (~clr_bit & pending_reg[gi]))
                                    : src_in[gi];
        end
    endgenerate

    assign active = pending_reg & enable_reg;

    intr_priority_encoder #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .active (active),
        .any    (any_active),
        .id     (top_id)
    );

    // src_prev follows src_in every cycle, so a level->edge mode switch
    // starts from the current line value and cannot see a false rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_reg       <= '0;
            mode_reg         <= '1;
            pending_reg      <= '0;
            src_prev_reg     <= '0;
            interrupt_signal <= 1'b0;
            irq_id           <= '0;
        end else begin
            if (wr_enable) enable_reg <= write_data;
            if (wr_mode)   mode_reg   <= write_data;
            pending_reg      <= pending_next;
            src_prev_reg     <= src_in;
            interrupt_signal <= any_active;
            irq_id           <= any_active ? top_id : '0;
        end
    end

    always_comb begin
        read_data = '0;
        case (read_addr)
            INTR_ADDR_ENABLE:  read_data = enable_reg;
            INTR_ADDR_PENDING: read_data = pending_reg;
            INTR_ADDR_MODE:    read_data = mode_reg;
            default:           read_data = src_in;
        endcase
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios followed by random traffic, checked against a behavioural model.
module tb_interrupt_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src_in = '0;
    logic       write_signal = 1'b0;
    logic [1:0] write_addr = '0;
    logic [3:0] write_data = '0;
    logic [1:0] read_addr = '0;
    logic [3:0] read_data;
    logic       irq_ack = 1'b0;
    logic       interrupt_signal;
    logic [1:0] irq_id;

    int pass_count = 0;
    int total_count = 0;

    // reference model state
    logic [3:0] m_en, m_pend, m_mode, m_prev;
    logic       m_irq;
    logic [1:0] m_id;

    interrupt_controller #(.N_SRC(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .src_in           (src_in),
        .write_signal     (write_signal),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .read_addr        (read_addr),
        .read_data        (read_data),
        .irq_ack          (irq_ack),
        .interrupt_signal (interrupt_signal),
        .irq_id           (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_en = '0; m_pend = '0; m_mode = 4'b1111; m_prev = '0;
        m_irq = 1'b0; m_id = '0;
    endtask

    // One clock of the controller's rules applied to the pre-edge model state.
    task automatic m_step(input logic [3:0] src, input logic w, input logic [1:0] wa,
                          input logic [3:0] wd, input logic ack);
        logic [3:0] act, np;
        logic       found;
        logic [1:0] nid;
        act = m_pend & m_en;
        found = 1'b0;
        nid = '0;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && !found) begin
                nid = 2'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!m_mode[i]) begin
                np[i] = src[i];
            end else if ((src[i] && !m_prev[i]) || (w && wa == 2'd3 && wd[i])) begin
                np[i] = 1'b1;
            end else if ((w && wa == 2'd1 && wd[i]) || (ack && m_irq && m_id == 2'(i))) begin
                np[i] = 1'b0;
            end else begin
                np[i] = m_pend[i];
            end
        end
        if (w && wa == 2'd0) m_en = wd;
        if (w && wa == 2'd2) m_mode = wd;
        m_pend = np;
        m_prev = src;
        m_irq = found;
        m_id = nid;
    endtask

    function automatic logic [3:0] m_read(input logic [1:0] ra, input logic [3:0] src);
        case (ra)
            2'd0:    return m_en;
            2'd1:    return m_pend;
            2'd2:    return m_mode;
            default: return src;
        endcase
    endfunction

    task automatic cycle(input logic [3:0] src, input logic w, input logic [1:0] wa,
                         input logic [3:0] wd, input logic ack, input logic [1:0] ra);
        src_in = src; write_signal = w; write_addr = wa; write_data = wd;
        irq_ack = ack; read_addr = ra;
        @(posedge clk);
        if (rst) m_reset();
        else m_step(src, w, wa, wd, ack);
        #1;
        $display("cyc src=%b w=%b a=%0d d=%b ack=%b ra=%0d | rd=%b irq=%b id=%0d",
                 src, w, wa, wd, ack, ra, read_data, interrupt_signal, irq_id);
        check("read_data", read_data, m_read(ra, src));
        check("interrupt_signal", interrupt_signal, m_irq);
        check("irq_id", irq_id, m_id);
    endtask

    initial begin
        m_reset();
        // T1 reset
        cycle(4'b0000, 0, 0, 4'h0, 0, 0);
        rst = 1'b0;
        cycle(4'b0000, 0, 0, 4'h0, 0, 0);
        check("T1_enable", read_data, 4'b0000);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        check("T1_pending", read_data, 4'b0000);
        cycle(4'b0000, 0, 0, 4'h0, 0, 2);
        check("T1_mode", read_data, 4'b1111);
        check("T1_irq", interrupt_signal, 1'b0);

        // T2 edge detection and ack
        cycle(4'b0000, 1, 0, 4'hF, 0, 1);
        cycle(4'b0000, 1, 2, 4'hF, 0, 1);
        cycle(4'b0100, 0, 0, 4'h0, 0, 1);
        check("T2_pending", read_data, 4'b0100);
        check("T2_irq_k", interrupt_signal, 1'b0);
        cycle(4'b0100, 0, 0, 4'h0, 0, 1);
        check("T2_irq_k1", interrupt_signal, 1'b1);
        check("T2_id", irq_id, 2'd2);
        cycle(4'b0100, 0, 0, 4'h0, 1, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        check("T2_deassert", interrupt_signal, 1'b0);

        // T3 priority among simultaneous sources
        cycle(4'b1010, 0, 0, 4'h0, 0, 1);
        check("T3_pending", read_data, 4'b1010);
        cycle(4'b1010, 0, 0, 4'h0, 0, 1);
        check("T3_id1", irq_id, 2'd1);
        cycle(4'b1010, 0, 0, 4'h0, 1, 1);
        cycle(4'b1010, 0, 0, 4'h0, 0, 1);
        check("T3_id3", irq_id, 2'd3);
        check("T3_still", interrupt_signal, 1'b1);
        cycle(4'b1010, 0, 0, 4'h0, 1, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        check("T3_done", interrupt_signal, 1'b0);

        // T4 set wins over simultaneous W1C
        cycle(4'b0001, 0, 0, 4'h0, 0, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        cycle(4'b0001, 1, 1, 4'b0001, 0, 1);
        check("T4_collision", read_data[0], 1'b1);
        cycle(4'b0001, 1, 1, 4'b0001, 0, 1);
        check("T4_cleared", read_data[0], 1'b0);

        // T5 masking, late enable, level mode
        cycle(4'b0000, 1, 0, 4'h0, 0, 1);
        cycle(4'b0000, 1, 1, 4'hF, 0, 1);
        cycle(4'b0010, 0, 0, 4'h0, 0, 1);
        cycle(4'b0010, 0, 0, 4'h0, 0, 1);
        check("T5_masked", interrupt_signal, 1'b0);
        check("T5_latched", read_data, 4'b0010);
        cycle(4'b0010, 1, 0, 4'b0010, 0, 1);
        cycle(4'b0010, 0, 0, 4'h0, 0, 1);
        check("T5_irq", interrupt_signal, 1'b1);
        check("T5_id", irq_id, 2'd1);
        cycle(4'b0010, 1, 2, 4'b1101, 0, 1);
        cycle(4'b0010, 0, 0, 4'h0, 0, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        check("T5_level_drop", interrupt_signal, 1'b0);

        // T6 soft set, then reset while asserted
        cycle(4'b0000, 1, 2, 4'hF, 0, 0);
        cycle(4'b0000, 1, 0, 4'b1000, 0, 0);
        cycle(4'b0000, 1, 3, 4'b1000, 0, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        check("T6_irq", interrupt_signal, 1'b1);
        check("T6_id", irq_id, 2'd3);
        rst = 1'b1;
        #1;
        m_reset();
        check("T6_async_irq", interrupt_signal, 1'b0);
        check("T6_async_id", irq_id, 2'd0);
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        rst = 1'b0;
        cycle(4'b0000, 0, 0, 4'h0, 0, 1);
        cycle(4'b0000, 0, 0, 4'h0, 0, 0);
        check("T6_after_release", interrupt_signal, 1'b0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] s, d;
            logic       w, a;
            logic [1:0] wa, ra;
            s  = 4'($urandom);
            d  = 4'($urandom);
            w  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 2) == 0);
            wa = 2'($urandom);
            ra = 2'($urandom);
            cycle(s, w, wa, d, a, ra);
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
